cbus_arbiter: RTL and testbench

Round-robin arbiter that merges several cached-bus (cbus) masters, e.g. the instruction-cache and data-cache refill/writeback ports, onto the single cbus port of the burst RAM model. It grants one master at a time and holds that grant for the whole burst, until the beat where the slave signals `ready` and `last`. It forwards that master's request unchanged and routes the slave's response back only to that master.

---
 rtl/cbus_arbiter.sv | 131 +++++++++++++
 tb/tb_cbus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin merge of several cbus masters onto one burst port.
// A grant is held from request until the slave returns ready && last.
package cbus_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [7:0]  len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

endpackage

module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic             clk,
   input  logic             resetn,
   input  cbus_req_t        ireqs  [NUM_MASTERS],
   output cbus_resp_t       iresps [NUM_MASTERS],
   output cbus_req_t        oreq,
   input  cbus_resp_t       oresp,
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [IDX_W:0]   NM       = NUM_MASTERS[IDX_W:0];
   localparam logic [IDX_W-1:0] LAST_IDX = NUM_MASTERS[IDX_W-1:0] - 1'b1;

   state_t                 state_q;
   logic [IDX_W-1:0]       grant_q;
   logic [IDX_W-1:0]       prio_q;

   logic [NUM_MASTERS-1:0]   vld;
   logic [2*NUM_MASTERS-1:0] rot;
   logic                     req_any;
   logic [IDX_W-1:0]         ofs;
   logic [IDX_W:0]           sum;
   logic [IDX_W-1:0]         grant_d;
   logic [IDX_W-1:0]         prio_d;
   logic                     done;

   // Rotate the valid vector so bit 0 is the master at prio_q; the
   // lowest set bit is then the round-robin winner's offset from prio_q.
   always_comb begin
      vld = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         vld[i] = ireqs[i].valid;
      end
      rot     = {vld, vld} >> prio_q;
      req_any = |vld;
      ofs     = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         if (rot[k]) begin
            ofs = IDX_W'(k);
         end
      end
      sum = {1'b0, prio_q} + {1'b0, ofs};
      if (sum >= NM) begin
         grant_d = IDX_W'(sum - NM);
      end else begin
         grant_d = sum[IDX_W-1:0];
      end
   end

   always_comb begin
      done   = oresp.ready && oresp.last;
      prio_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         prio_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_any) begin
                  grant_q <= grant_d;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  state_q <= IDLE;
                  prio_q  <= prio_d;
               end
            end
         endcase
      end
   end

   // Request and response paths are pure muxes; non-grantees see zeros.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         iresps[i] = '0;
         if (state_q == BUSY && grant_q == IDX_W'(i)) begin
            oreq      = ireqs[i];
            iresps[i] = oresp;
         end
      end
   end

   assign busy      = (state_q == BUSY);
   assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with two masters and a hand-driven slave.
// Each task drives one scenario and checks expected values inline.
module tb_cbus_arbiter;
   import cbus_pkg::*;

   logic       clk;
   logic       resetn;
   cbus_req_t  ireqs  [2];
   cbus_resp_t iresps [2];
   cbus_req_t  oreq;
   cbus_resp_t oresp;
   logic       busy;
   logic [0:0] grant_idx;

   int n_vec;
   int n_err;

   cbus_arbiter #(.NUM_MASTERS(2)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .ireqs     (ireqs),
      .iresps    (iresps),
      .oreq      (oreq),
      .oresp     (oresp),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      ireqs[0] = '0;
      ireqs[1] = '0;
      oresp    = '0;
      step();
      step();
      resetn = 1'b1;
      ireqs[1].valid = 1'b1;
      ireqs[1].len   = 8'd3;
      step();
      n_vec++;
      if ({busy, grant_idx} !== 2'b11) begin
         n_err++;
         $display("FAIL pre_reset_grant: got %b want 11", {busy, grant_idx});
      end
      #2 resetn = 1'b0;
      #1;
      n_vec++;
      if ({oreq.valid, busy, grant_idx} !== 3'b000) begin
         n_err++;
         $display("FAIL async_reset: got %b want 000",
                  {oreq.valid, busy, grant_idx});
      end
      step();
      step();
      n_vec++;
      if ({oreq.valid, busy, grant_idx} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_hold: got %b want 000",
                  {oreq.valid, busy, grant_idx});
      end
      ireqs[1] = '0;
      resetn   = 1'b1;
      step();
   endtask

   task automatic test_single_burst();
      cbus_req_t  exp;
      cbus_resp_t rsp;
      logic [63:0] beats [4];
      beats[0] = 64'h11;
      beats[1] = 64'h22;
      beats[2] = 64'h33;
      beats[3] = 64'h44;
      exp = '0;
      exp.valid = 1'b1;
      exp.size  = 3'd3;
      exp.addr  = 32'h8000_0040;
      exp.len   = 8'd3;
      exp.burst = BURST_INCR;
      ireqs[1] = exp;
      #1;
      n_vec++;
      if (oreq !== '0) begin
         n_err++;
         $display("FAIL single_idle_oreq: got %h want 0", oreq);
      end
      step();
      n_vec++;
      if (oreq !== exp || grant_idx !== 1'b1) begin
         n_err++;
         $display("FAIL single_oreq: got %h/%b want %h/1",
                  oreq, grant_idx, exp);
      end
      for (int b = 0; b < 4; b++) begin
         rsp.ready = 1'b1;
         rsp.last  = (b == 3);
         rsp.data  = beats[b];
         oresp = rsp;
         #1;
         n_vec++;
         if (iresps[1] !== rsp || iresps[0] !== '0) begin
            n_err++;
            $display("FAIL single_beat%0d: got %h/%h want %h/0",
                     b, iresps[1], iresps[0], rsp);
         end
         step();
      end
      oresp    = '0;
      ireqs[1] = '0;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_release: got busy=%b want 0", busy);
      end
      step();
   endtask

   task automatic test_round_robin();
      logic g;
      resetn = 1'b0;
      ireqs[0] = '0;
      ireqs[1] = '0;
      ireqs[0].valid = 1'b1;
      ireqs[0].len   = 8'd1;
      ireqs[1].valid = 1'b1;
      ireqs[1].len   = 8'd1;
      step();
      resetn = 1'b1;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rr_start_idle: got busy=%b want 0", busy);
      end
      step();
      for (int n = 0; n < 4; n++) begin
         g = 1'(n % 2);
         n_vec++;
         if ({busy, grant_idx} !== {1'b1, g}) begin
            n_err++;
            $display("FAIL rr_grant%0d: got %b want %b",
                     n, {busy, grant_idx}, {1'b1, g});
         end
         oresp = '{ready: 1'b1, last: 1'b0, data: 64'(n)};
         #1;
         n_vec++;
         if (iresps[g].ready !== 1'b1 || iresps[~g] !== '0) begin
            n_err++;
            $display("FAIL rr_route%0d: got %b/%h want 1/0",
                     n, iresps[g].ready, iresps[~g]);
         end
         step();
         oresp = '{ready: 1'b1, last: 1'b1, data: 64'(n)};
         step();
         oresp = '0;
         if (n == 3) begin
            ireqs[0] = '0;
            ireqs[1] = '0;
         end
         #1;
         n_vec++;
         if ({busy, oreq.valid} !== 2'b00) begin
            n_err++;
            $display("FAIL rr_bubble%0d: got %b want 00",
                     n, {busy, oreq.valid});
         end
         step();
      end
   endtask

   task automatic test_write();
      ireqs[0] = '0;
      ireqs[0].valid    = 1'b1;
      ireqs[0].is_write = 1'b1;
      ireqs[0].size     = 3'd2;
      ireqs[0].addr     = 32'h4060_0004;
      ireqs[0].data     = 64'h0000_0041_0000_0000;
      ireqs[0].strobe   = 8'h10;
      ireqs[0].burst    = BURST_INCR;
      step();
      n_vec++;
      if ({oreq.valid, oreq.is_write, grant_idx} !== 3'b110) begin
         n_err++;
         $display("FAIL wr_ctrl: got %b want 110",
                  {oreq.valid, oreq.is_write, grant_idx});
      end
      n_vec++;
      if (oreq.data !== 64'h0000_0041_0000_0000 || oreq.strobe !== 8'h10 ||
          oreq.addr !== 32'h4060_0004) begin
         n_err++;
         $display("FAIL wr_payload: got %h/%h/%h want 4060_0004/41_0000_0000/10",
                  oreq.addr, oreq.data, oreq.strobe);
      end
      oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
      #1;
      n_vec++;
      if (iresps[0].last !== 1'b1 || iresps[1] !== '0) begin
         n_err++;
         $display("FAIL wr_resp: got %b/%h want 1/0",
                  iresps[0].last, iresps[1]);
      end
      step();
      oresp    = '0;
      ireqs[0] = '0;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL wr_release: got busy=%b want 0", busy);
      end
      step();
   endtask

   task automatic test_reset_mid_burst();
      ireqs[1] = '0;
      ireqs[1].valid = 1'b1;
      ireqs[1].len   = 8'd7;
      ireqs[1].addr  = 32'h8000_0100;
      ireqs[1].burst = BURST_INCR;
      step();
      n_vec++;
      if ({busy, grant_idx} !== 2'b11) begin
         n_err++;
         $display("FAIL mid_grant: got %b want 11", {busy, grant_idx});
      end
      oresp = '{ready: 1'b1, last: 1'b0, data: 64'hA1};
      step();
      oresp = '{ready: 1'b1, last: 1'b0, data: 64'hA2};
      #2;
      resetn = 1'b0;
      ireqs[0] = '0;
      ireqs[0].valid = 1'b1;
      #1;
      n_vec++;
      if (oreq !== '0 || iresps[1] !== '0 || {busy, grant_idx} !== 2'b00) begin
         n_err++;
         $display("FAIL mid_clear: got %h/%h/%b want 0/0/00",
                  oreq, iresps[1], {busy, grant_idx});
      end
      oresp = '0;
      step();
      step();
      resetn = 1'b1;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL mid_release_idle: got busy=%b want 0", busy);
      end
      step();
      n_vec++;
      if ({busy, grant_idx} !== 2'b10) begin
         n_err++;
         $display("FAIL mid_regrant: got %b want 10", {busy, grant_idx});
      end
      oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
      step();
      oresp    = '0;
      ireqs[0] = '0;
      ireqs[1] = '0;
      step();
   endtask

   task automatic test_early_drop();
      ireqs[0] = '0;
      ireqs[0].valid = 1'b1;
      ireqs[0].len   = 8'd5;
      step();
      ireqs[1] = '0;
      ireqs[1].valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         oresp = '{ready: 1'b1, last: 1'b0, data: 64'(c)};
         if (c == 1) ireqs[0].valid = 1'b0;
         #1;
         n_vec++;
         if ({busy, grant_idx, oreq.valid} !== {2'b10, c == 0}) begin
            n_err++;
            $display("FAIL drop_hold%0d: got %b want %b",
                     c, {busy, grant_idx, oreq.valid}, {2'b10, c == 0});
         end
         n_vec++;
         if (iresps[0].ready !== 1'b1 || iresps[1] !== '0) begin
            n_err++;
            $display("FAIL drop_route%0d: got %b/%h want 1/0",
                     c, iresps[0].ready, iresps[1]);
         end
         step();
      end
      n_vec++;
      if ({busy, grant_idx} !== 2'b10) begin
         n_err++;
         $display("FAIL drop_still_busy: got %b want 10", {busy, grant_idx});
      end
      oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
      step();
      oresp = '0;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL drop_release: got busy=%b want 0", busy);
      end
      step();
      n_vec++;
      if ({busy, grant_idx} !== 2'b11) begin
         n_err++;
         $display("FAIL drop_next: got %b want 11", {busy, grant_idx});
      end
      oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
      step();
      oresp    = '0;
      ireqs[1] = '0;
      step();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single_burst();
      test_round_robin();
      test_write();
      test_reset_mid_burst();
      test_early_drop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
